riscv_lsu_fsm: RTL and testbench

- Next-generation load/store unit between the core datapath and the data memory port.
- Replaces combinational pass-through with a registered request/ready state machine: requests are captured, issued, and held until memory acknowledges.
- Adds a bus timeout and access-error reporting.
- Optionally splits misaligned half/word accesses into two aligned memory transactions.

---
 rtl/riscv_lsu_fsm.sv | 190 +++++++++++++++++++
 tb/tb_riscv_lsu_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_fsm.sv
// rtl/riscv_lsu_fsm.sv - registered load/store unit FSM with bus timeout and access-error reporting
// Optional misaligned access splitting is enabled by defining RISCV_LSU_MISALIGN_SPLIT_EN.
module riscv_lsu_fsm #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;
  logic [31:0]       lo_data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              size_ok, align_ok;
  logic [1:0]        off;
  logic [3:0]        base_be, be_lo, be_hi;
  logic              crosses;
  logic [63:0]       wd_dbl, merged_dbl;
  logic [31:0]       res_lo, merged, ext_data;
  logic [ADDR_W-1:0] word_addr, hi_addr;
  logic              tmo_hit;

  logic              capture_req, capture_lo, cnt_clr, cnt_inc, resp_set, resp_err;

  always_comb begin
    size_ok = (core_size_i == LDST_B) || (core_size_i == LDST_H) || (core_size_i == LDST_W) ||
              (core_size_i == LDST_BU) || (core_size_i == LDST_HU);
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
    align_ok = 1'b1;
`else
    align_ok = (core_size_i[1:0] == 2'd0) ||
               (core_size_i[1:0] == 2'd1 && !core_addr_i[0]) ||
               (core_size_i[1:0] == 2'd2 && core_addr_i[1:0] == 2'b00);
`endif
  end

  always_comb begin
    off = addr_q[1:0];
    case (size_q[1:0])
      2'd0:    base_be = 4'b0001;
      2'd1:    base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
    be_lo = base_be << off;
    be_hi = base_be >> (3'd4 - {1'b0, off});
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
    crosses = |be_hi;
`else
    crosses = 1'b0;
`endif
    wd_dbl    = {wd_q, wd_q} << {off, 3'b000};
    word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    hi_addr   = word_addr + ADDR_W'(4);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);
  end

  // Final data arrives on mem_rd_i in the same cycle the response is registered.
  always_comb begin
    res_lo     = (state == HI) ? lo_data_q : mem_rd_i;
    merged_dbl = {mem_rd_i, res_lo} >> {off, 3'b000};
    merged     = merged_dbl[31:0];
    case (size_q)
      LDST_B:  ext_data = {{24{merged[7]}}, merged[7:0]};
      LDST_H:  ext_data = {{16{merged[15]}}, merged[15:0]};
      LDST_BU: ext_data = {24'b0, merged[7:0]};
      LDST_HU: ext_data = {16'b0, merged[15:0]};
      default: ext_data = merged;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wd_o     = 32'b0;
    capture_req  = 1'b0;
    capture_lo   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    resp_set     = 1'b0;
    resp_err     = 1'b0;
    case (state)
      IDLE: begin
        if (core_req_i) begin
          core_stall_o = 1'b1;
          capture_req  = 1'b1;
          cnt_clr      = 1'b1;
          if (!size_ok || !align_ok) begin
            state_nxt = RESP;
            resp_set  = 1'b1;
            resp_err  = 1'b1;
          end else begin
            state_nxt = LO;
          end
        end
      end
      LO, HI: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = we_q;
        mem_be_o     = (state == LO) ? be_lo : be_hi;
        mem_addr_o   = (state == LO) ? word_addr : hi_addr;
        mem_wd_o     = wd_dbl[63:32];
        if (mem_ready_i) begin
          cnt_clr = 1'b1;
          if (state == LO && crosses) begin
            capture_lo = 1'b1;
            state_nxt  = HI;
          end else begin
            state_nxt = RESP;
            resp_set  = 1'b1;
          end
        end else if (tmo_hit) begin
          cnt_clr   = 1'b1;
          state_nxt = RESP;
          resp_set  = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 3'b0;
      addr_q    <= '0;
      wd_q      <= 32'b0;
      lo_data_q <= 32'b0;
      cnt_q     <= '0;
      core_rd_o <= 32'b0;
      core_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture_req) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
      end
      if (capture_lo) lo_data_q <= mem_rd_i;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      // Stores and failed accesses return zero so stale data never leaks to the core.
      if (resp_set) begin
        core_err_o <= resp_err;
        core_rd_o  <= (resp_err || we_q) ? 32'b0 : ext_data;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu_fsm.sv
// tb/tb_riscv_lsu_fsm.sv - self-checking bench for riscv_lsu_fsm against a byte-level access model
module tb_riscv_lsu_fsm;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, core_err;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_rd;
  logic        last_err;

  always #5 clk = ~clk;

  riscv_lsu_fsm #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  function automatic logic [31:0] memword(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core access; d0/d1 are ready delays for the first/second memory transaction.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int d0, input int d1,
                            output logic [31:0] rd, output logic err);
    int n, nacc, exp_nacc, exp_cyc, done_exp, idx, wait_n, cyc, k, s;
    bit legal, exp_err, got;
    logic [31:0] waddr [2];
    logic [3:0]  be [2];
    logic [31:0] ewd, bytes_val, exp_rd, b, w;
    int dly [2];

    n = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    legal = (size == 3'd0 || size == 3'd1 || size == 3'd2 || size == 3'd4 || size == 3'd5);
`ifndef RISCV_LSU_MISALIGN_SPLIT_EN
    if ((addr % n) != 0) legal = 1'b0;
`endif
    waddr[0] = {addr[31:2], 2'b00};
    waddr[1] = waddr[0] + 32'd4;
    be[0] = 4'b0; be[1] = 4'b0;
    nacc = 1;
    bytes_val = 32'b0;
    for (int i = 0; i < n; i++) begin
      b = addr + i;
      k = ({b[31:2], 2'b00} == waddr[0]) ? 0 : 1;
      if (k == 1) nacc = 2;
      be[k][b[1:0]] = 1'b1;
      w = memword({b[31:2], 2'b00});
      bytes_val[8*i +: 8] = w[8*b[1:0] +: 8];
    end
    for (int l = 0; l < 4; l++) begin
      s = (l - int'(addr[1:0])) & 3;
      ewd[8*l +: 8] = wd[8*s +: 8];
    end
    case (size)
      3'd0:    exp_rd = {{24{bytes_val[7]}}, bytes_val[7:0]};
      3'd1:    exp_rd = {{16{bytes_val[15]}}, bytes_val[15:0]};
      3'd4:    exp_rd = {24'b0, bytes_val[7:0]};
      3'd5:    exp_rd = {16'b0, bytes_val[15:0]};
      default: exp_rd = bytes_val;
    endcase
    dly[0] = d0; dly[1] = d1;
    exp_err = !legal;
    exp_nacc = legal ? nacc : 0;
    exp_cyc = 1;
    done_exp = 0;
    for (int a = 0; a < exp_nacc; a++) begin
      if (dly[a] >= TMO) begin
        exp_cyc += TMO;
        exp_err = 1'b1;
        break;
      end
      exp_cyc += dly[a] + 1;
      done_exp++;
    end
    if (exp_err || we) exp_rd = 32'b0;

    @(negedge clk);
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    #1;
    check("stall_on_request", {31'b0, core_stall}, 32'd1);
    check("rd_hold", core_rd, last_rd);
    check("err_hold", {31'b0, core_err}, {31'b0, last_err});

    idx = 0; wait_n = 0; got = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rd = $urandom;
      if (!core_stall) begin
        got = 1'b1;
        break;
      end
      if (mem_req) begin
        if (wait_n == 0) check("access_in_range", {31'b0, idx < exp_nacc}, 32'd1);
        if (idx < exp_nacc) begin
          check("mem_addr", mem_addr, waddr[idx]);
          check("mem_be", {28'b0, mem_be}, {28'b0, be[idx]});
          check("mem_we", {31'b0, mem_we}, {31'b0, we});
          check("mem_wd", mem_wd, ewd);
          if (wait_n == dly[idx]) begin
            mem_ready = 1'b1;
            mem_rd = memword(waddr[idx]);
            idx++;
            wait_n = 0;
          end else begin
            wait_n++;
          end
        end
      end
    end
    check("resp_seen", {31'b0, got}, 32'd1);
    if (got) begin
      check("resp_latency", cyc, exp_cyc);
      check("resp_err", {31'b0, core_err}, {31'b0, exp_err});
      check("resp_rd", core_rd, exp_rd);
      check("resp_mem_req", {31'b0, mem_req}, 32'd0);
      check("accesses_done", idx, done_exp);
    end
    rd = core_rd;
    err = core_err;
    last_rd = core_rd;
    last_err = core_err;
    core_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] ra;

    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = 32'b0; core_wd = 32'b0; mem_rd = 32'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check("reset_mem_be", {28'b0, mem_be}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wd", mem_wd, 32'd0);
    check("reset_core_rd", core_rd, 32'd0);
    check("reset_core_err", {31'b0, core_err}, 32'd0);
    check("reset_stall", {31'b0, core_stall}, 32'd0);
    rst = 1'b0;
    last_rd = 32'b0;
    last_err = 1'b0;

    run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, rd, err);
    check("sw_err", {31'b0, err}, 32'd0);

    mem[32'h100] = 32'h8012_3456;
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, rd, err);
    check("lb_result", rd, 32'hFFFF_FF80);
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 1, 0, rd, err);
    check("lbu_result", rd, 32'h0000_0080);

    run_access(1'b1, 3'd1, 32'h102, 32'h0000_1234, 0, 0, rd, err);
    mem[32'h100] = 32'hABCD_0000;
    run_access(1'b0, 3'd5, 32'h102, 32'h0, 2, 0, rd, err);
    check("lhu_result", rd, 32'h0000_ABCD);

    mem[32'h1FC] = 32'h2211_5566;
    mem[32'h200] = 32'h7788_4433;
    run_access(1'b0, 3'd2, 32'h1FE, 32'h0, 0, 0, rd, err);
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
    check("lw_split_result", rd, 32'h4433_2211);
    check("lw_split_err", {31'b0, err}, 32'd0);
`else
    check("lw_misaligned_result", rd, 32'h0);
    check("lw_misaligned_err", {31'b0, err}, 32'd1);
`endif

    run_access(1'b0, 3'd2, 32'h10, 32'h0, 100, 0, rd, err);
    check("timeout_err", {31'b0, err}, 32'd1);
    check("timeout_rd", rd, 32'h0);
    @(negedge clk);
    check("timeout_mem_req_after", {31'b0, mem_req}, 32'd0);

    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h10; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_lo_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    core_req = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_stall", {31'b0, core_stall}, 32'd0);
    rst = 1'b0;
    last_rd = 32'b0;
    last_err = 1'b0;
    mem[32'h10] = 32'hCAFE_F00D;
    run_access(1'b0, 3'd2, 32'h10, 32'h0, 0, 0, rd, err);
    check("after_reset_lw", rd, 32'hCAFE_F00D);

    for (int t = 0; t < 300; t++) begin
      int d0, d1;
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else ra = $urandom_range(0, 4095);
      d0 = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, 3);
      d1 = ($urandom_range(0, 11) == 0) ? TMO + 3 : $urandom_range(0, 3);
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, d0, d1, rd, err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
